// File: rtl/mu0_arbmux.sv
// mu0_arbmux: N-channel registered multiplexer with a directed-select mode and a
// round-robin arbitration mode, followed by a one-deep valid/ready output register.
//
// Ports:
//   Clk     - clock, rising edge
//   nReset  - asynchronous active-low reset
//   D       - packed channel data, channel i at [i*WIDTH +: WIDTH]
//   Req     - per-channel request (data valid)
//   Mode    - 0: directed select by Sel, 1: round-robin arbitration
//   Sel     - channel index used in directed mode
//   Ready   - consumer accepts Q this cycle
//   Q       - registered selected data
//   Valid   - Q holds unconsumed data
//   Grant   - combinational one-hot: channel captured at the coming edge
module mu0_arbmux #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned CHANNELS = 4,
    localparam int unsigned SW      = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
    input  logic                      Clk,
    input  logic                      nReset,
    input  logic [CHANNELS*WIDTH-1:0] D,
    input  logic [CHANNELS-1:0]       Req,
    input  logic                      Mode,
    input  logic [SW-1:0]             Sel,
    input  logic                      Ready,
    output logic [WIDTH-1:0]          Q,
    output logic                      Valid,
    output logic [CHANNELS-1:0]       Grant
);

    localparam int NCH = int'(CHANNELS);

    logic [WIDTH-1:0]    q_q, q_d;
    logic                valid_q, valid_d;
    logic [SW-1:0]       ptr_q, ptr_d;

    logic                load_opp;
    logic                found;
    logic [SW-1:0]       sel_idx;
    logic [WIDTH-1:0]    sel_data;
    logic [CHANNELS-1:0] grant_w;
    int                  idx;

    // Channel selection: never looks at D, so Grant is independent of data.
    always_comb begin
        load_opp = !valid_q || Ready;
        found    = 1'b0;
        sel_idx  = '0;
        idx      = 0;
        if (load_opp) begin
            if (!Mode) begin
                // Sel values with no matching channel select nothing.
                for (int i = 0; i < NCH; i++) begin
                    if (Sel == SW'(i) && Req[i]) begin
                        found   = 1'b1;
                        sel_idx = SW'(i);
                    end
                end
            end else begin
                // Search starts just after the last round-robin winner.
                for (int off = 1; off <= NCH; off++) begin
                    idx = (int'(ptr_q) + off) % NCH;
                    if (!found && Req[idx]) begin
                        found   = 1'b1;
                        sel_idx = SW'(idx);
                    end
                end
            end
        end
    end

    always_comb begin
        grant_w  = '0;
        sel_data = '0;
        for (int i = 0; i < NCH; i++) begin
            grant_w[i] = found && (sel_idx == SW'(i));
            if (sel_idx == SW'(i)) begin
                sel_data = D[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        q_d     = q_q;
        ptr_d   = ptr_q;
        if (load_opp) begin
            valid_d = found;
            if (found) begin
                q_d = sel_data;
                // Directed grants must not disturb round-robin fairness.
                if (Mode) begin
                    ptr_d = sel_idx;
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            q_q     <= '0;
            valid_q <= 1'b0;
            ptr_q   <= SW'(CHANNELS - 1);
        end else begin
            q_q     <= q_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    // While in reset the output register looks empty, so mask Grant explicitly.
    assign Grant = nReset ? grant_w : '0;
    assign Q     = q_q;
    assign Valid = valid_q;

endmodule

// File: doc/mu0_arbmux.md
MU0_ARBMUX -- requirements
Module: mu0_arbmux

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning data width per channel.
REQ-002 The block SHALL have parameter CHANNELS, default 4, legal range 2..8, meaning number of input channels.
REQ-003 The block SHALL use SW = clog2(CHANNELS), minimum 1, as the select width.
REQ-004 Port Clk SHALL be an input, width 1: the single clock, with all state updated on the rising edge.
REQ-005 Port nReset SHALL be an input, width 1: asynchronous, active-low reset.
REQ-006 Port D SHALL be an input, width CHANNELS*WIDTH: packed channel data, with channel i at bits [i*WIDTH +: WIDTH].
REQ-007 Port Req SHALL be an input, width CHANNELS: per-channel request, where bit i means D channel i is valid.
REQ-008 Port Mode SHALL be an input, width 1: 0 = directed select, 1 = round-robin arbitration.
REQ-009 Port Sel SHALL be an input, width SW: channel index used when Mode=0.
REQ-010 Port Ready SHALL be an input, width 1: consumer accepts Q this cycle.
REQ-011 Port Q SHALL be an output, width WIDTH: registered selected data.
REQ-012 Port Valid SHALL be an output, width 1: Q holds unconsumed data.
REQ-013 Port Grant SHALL be an output, width CHANNELS: combinational one-hot acceptance, where bit i means channel i's data is captured at the coming edge.

Function
REQ-014 A load opportunity SHALL exist in any cycle where (Valid==0 or Ready==1).
REQ-015 In a cycle without a load opportunity, the block SHALL hold Q and Valid, drive Grant to 0, and leave the round-robin pointer unchanged.
REQ-016 At a load opportunity with Mode=0, the block SHALL select channel Sel if Sel<CHANNELS and Req[Sel]==1; otherwise no channel is selected.
REQ-017 At a load opportunity with Mode=1, the block SHALL select the first i with Req[i]==1, searching Ptr+1, Ptr+2, ..., wrapping modulo CHANNELS, ending at Ptr.
REQ-018 If a channel k is selected, the block SHALL drive Grant to onehot(k) in that cycle, and at the edge load Q<=D[k] and set Valid<=1.
REQ-019 If no channel is selected at a load opportunity, the block SHALL keep Grant at 0, clear Valid<=0 at the edge, and hold Q at its previous value.
REQ-020 The round-robin pointer Ptr (width SW) SHALL update to k only on a Mode=1 grant; Mode=0 grants SHALL leave Ptr unchanged.
REQ-021 Latency from Grant to Valid with the corresponding Q SHALL be exactly 1 cycle, and with Ready held 1 the block SHALL sustain one transfer per cycle.
REQ-022 Mode and Sel SHALL be sampled only at load opportunities; a change during a stall SHALL not affect the held Q or Valid.
REQ-023 The block SHALL make Grant depend on Req, Mode, Sel, Ptr, Valid and Ready only, never on D.
REQ-024 With CHANNELS not a power of two, the block SHALL treat Sel values >= CHANNELS as no request, and Ptr SHALL never take a value >= CHANNELS.

Reset
REQ-025 While nReset==0, the block SHALL force Q=0, Valid=0 and Ptr=CHANNELS-1 immediately, without waiting for Clk.
REQ-026 While nReset==0, the block SHALL force Grant=0.
REQ-027 After reset release, the first Mode=1 arbitration SHALL favour channel 0.
REQ-028 Reset asserted during a stall SHALL discard the held word.

Verification
REQ-029 The bench SHALL cover directed select (WIDTH=16, CHANNELS=4): Mode=0, Sel=1, Req=0010, D ch1=0x0015, Ready=1 -> Grant=0010 that cycle, then Q=0x0015 and Valid=1 after the edge.
REQ-030 The bench SHALL cover round-robin fairness: Mode=1, Req=1111, Ready=1 held -> Grant sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles.
REQ-031 The bench SHALL cover a stall: Valid=1, Q=0xFFFE, Ready=0 for 3 cycles while D and Req change -> Q stays 0xFFFE, Valid stays 1, Grant=0000, Ptr unchanged.
REQ-032 The bench SHALL cover wrap-around: Ptr=3, Mode=1, Req=1001 -> Grant=0001, then Grant=1000 on the next cycle.
REQ-033 The bench SHALL cover reset mid-operation: nReset=0 asynchronously while Valid=1 -> Q=0x0000, Valid=0, Grant=0000 immediately; after release with Mode=1, Req=1111 -> Grant=0001.
REQ-034 The bench SHALL cover an out-of-range select (CHANNELS=3): Mode=0, Sel=3, Req=111 -> Grant=000, Valid=0 after the edge, and Q unchanged.
